// File: rtl/synthetic_1_seq.sv
// Sequencer for a fill/heat/mix/filter/mix/detect protocol.
// Every output is registered and is decoded from the next state. The only exception is result.
module synthetic_1_seq #(
   parameter int T_FILL   = 4,
   parameter int T_HEAT   = 8,
   parameter int T_MIX    = 6,
   parameter int T_FILT   = 3,
   parameter int T_DET_TO = 16,
   parameter int CNT_W    = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       abort,
   input  logic       det_valid,
   input  logic [7:0] det_value,
   output logic [2:0] src_valve,
   output logic [1:0] heater_en,
   output logic [1:0] flow_en,
   output logic [1:0] mixer_en,
   output logic       det_req,
   output logic       busy,
   output logic       done,
   output logic       err,
   output logic [7:0] result,
   output logic [3:0] step
);

   localparam int MAX_T = (1 << CNT_W) - 1;

   if (T_FILL > MAX_T || T_HEAT > MAX_T || T_MIX > MAX_T ||
       T_FILT > MAX_T || T_DET_TO > MAX_T) begin : g_param_check
      $error("synthetic_1_seq: a duration parameter does not fit in CNT_W bits");
   end

   typedef enum logic [3:0] {
      S_IDLE   = 4'd0,
      S_FILL   = 4'd1,
      S_HEAT   = 4'd2,
      S_MIX_A  = 4'd3,
      S_FILT   = 4'd4,
      S_MIX_B  = 4'd5,
      S_DETECT = 4'd6,
      S_DONE   = 4'd7,
      S_ERROR  = 4'd8
   } state_t;

   // A zero duration behaves like one cycle, so the load value is max(t,1)-1.
   function automatic logic [CNT_W-1:0] load_val(input int t);
      return (t > 1) ? CNT_W'(t - 1) : {CNT_W{1'b0}};
   endfunction

   localparam logic [CNT_W-1:0] LD_FILL = load_val(T_FILL);
   localparam logic [CNT_W-1:0] LD_HEAT = load_val(T_HEAT);
   localparam logic [CNT_W-1:0] LD_MIX  = load_val(T_MIX);
   localparam logic [CNT_W-1:0] LD_FILT = load_val(T_FILT);
   localparam logic [CNT_W-1:0] LD_DET  = load_val(T_DET_TO);
   localparam logic [CNT_W-1:0] CNT_Z   = {CNT_W{1'b0}};

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [7:0]       result_q, result_d;
   logic [2:0]       src_valve_q, src_valve_d;
   logic [1:0]       heater_en_q, heater_en_d;
   logic [1:0]       flow_en_q, flow_en_d;
   logic [1:0]       mixer_en_q, mixer_en_d;
   logic             det_req_q, det_req_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             err_q, err_d;
   logic             cnt_zero;

   assign cnt_zero = (cnt_q == CNT_Z);

   // Next state, step counter and captured result. Abort beats every busy-state event.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      case (state_q)
         S_IDLE, S_DONE, S_ERROR: begin
            cnt_d = CNT_Z;
            if (start) begin
               state_d = S_FILL;
               cnt_d   = LD_FILL;
            end else begin
               state_d = state_q;
            end
         end
         S_FILL, S_HEAT, S_MIX_A, S_FILT, S_MIX_B: begin
            if (abort) begin
               state_d = S_IDLE;
               cnt_d   = CNT_Z;
            end else if (!cnt_zero) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else begin
               case (state_q)
                  S_FILL:  begin state_d = S_HEAT;   cnt_d = LD_HEAT; end
                  S_HEAT:  begin state_d = S_MIX_A;  cnt_d = LD_MIX;  end
                  S_MIX_A: begin state_d = S_FILT;   cnt_d = LD_FILT; end
                  S_FILT:  begin state_d = S_MIX_B;  cnt_d = LD_MIX;  end
                  S_MIX_B: begin state_d = S_DETECT; cnt_d = LD_DET;  end
                  default: begin state_d = S_IDLE;   cnt_d = CNT_Z;   end
               endcase
            end
         end
         S_DETECT: begin
            if (abort) begin
               state_d = S_IDLE;
               cnt_d   = CNT_Z;
            end else if (det_valid) begin
               state_d  = S_DONE;
               cnt_d    = CNT_Z;
               result_d = det_value;
            end else if (!cnt_zero) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else begin
               state_d = S_ERROR;
               cnt_d   = CNT_Z;
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = CNT_Z;
         end
      endcase
   end

   // Output decode from the next state, so the registered outputs track the state register.
   always_comb begin
      src_valve_d = 3'b000;
      heater_en_d = 2'b00;
      flow_en_d   = 2'b00;
      mixer_en_d  = 2'b00;
      det_req_d   = 1'b0;
      busy_d      = 1'b0;
      done_d      = 1'b0;
      err_d       = 1'b0;
      case (state_d)
         S_FILL:   begin src_valve_d = 3'b111; busy_d = 1'b1; end
         S_HEAT:   begin heater_en_d = 2'b11; flow_en_d = 2'b01; busy_d = 1'b1; end
         S_MIX_A:  begin mixer_en_d = 2'b01; busy_d = 1'b1; end
         S_FILT:   begin flow_en_d = 2'b10; busy_d = 1'b1; end
         S_MIX_B:  begin mixer_en_d = 2'b10; busy_d = 1'b1; end
         S_DETECT: begin det_req_d = 1'b1; busy_d = 1'b1; end
         S_DONE:   done_d = 1'b1;
         S_ERROR:  err_d = 1'b1;
         default:  busy_d = 1'b0;
      endcase
   end

   // State, counter and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         cnt_q       <= CNT_Z;
         result_q    <= 8'h00;
         src_valve_q <= 3'b000;
         heater_en_q <= 2'b00;
         flow_en_q   <= 2'b00;
         mixer_en_q  <= 2'b00;
         det_req_q   <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         result_q    <= result_d;
         src_valve_q <= src_valve_d;
         heater_en_q <= heater_en_d;
         flow_en_q   <= flow_en_d;
         mixer_en_q  <= mixer_en_d;
         det_req_q   <= det_req_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         err_q       <= err_d;
      end
   end

   assign src_valve = src_valve_q;
   assign heater_en = heater_en_q;
   assign flow_en   = flow_en_q;
   assign mixer_en  = mixer_en_q;
   assign det_req   = det_req_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign err       = err_q;
   assign result    = result_q;
   assign step      = state_q;

endmodule

// File: tb/tb_synthetic_1_seq.sv
// Directed bench for synthetic_1_seq.
// A second instance with T_FILT=0 covers the zero-duration case.
module tb_synthetic_1_seq;

   logic       clk;
   logic       rst_n, start, abort, det_valid, start2;
   logic [7:0] det_value;
   logic [2:0] src_valve, src_valve2;
   logic [1:0] heater_en, flow_en, mixer_en, heater_en2, flow_en2, mixer_en2;
   logic       det_req, busy, done, err, det_req2, busy2, done2, err2;
   logic [7:0] result, result2;
   logic [3:0] step, step2;
   logic [12:0] obs;

   int n_checks = 0;
   int n_fail = 0;
   int busy_cycles = 0;

   localparam logic [12:0] A_IDLE = 13'b000_00_00_00_0_0_0_0;
   localparam logic [12:0] A_FILL = 13'b111_00_00_00_0_1_0_0;
   localparam logic [12:0] A_HEAT = 13'b000_11_01_00_0_1_0_0;
   localparam logic [12:0] A_MIXA = 13'b000_00_00_01_0_1_0_0;
   localparam logic [12:0] A_FILT = 13'b000_00_10_00_0_1_0_0;
   localparam logic [12:0] A_MIXB = 13'b000_00_00_10_0_1_0_0;
   localparam logic [12:0] A_DET  = 13'b000_00_00_00_1_1_0_0;
   localparam logic [12:0] A_DONE = 13'b000_00_00_00_0_0_1_0;
   localparam logic [12:0] A_ERR  = 13'b000_00_00_00_0_0_0_1;

   assign obs = {src_valve, heater_en, flow_en, mixer_en, det_req, busy, done, err};

   synthetic_1_seq u_dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .det_valid(det_valid), .det_value(det_value),
      .src_valve(src_valve), .heater_en(heater_en), .flow_en(flow_en),
      .mixer_en(mixer_en), .det_req(det_req), .busy(busy), .done(done),
      .err(err), .result(result), .step(step)
   );

   synthetic_1_seq #(.T_FILT(0)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .start(start2), .abort(1'b0),
      .det_valid(1'b0), .det_value(8'h00),
      .src_valve(src_valve2), .heater_en(heater_en2), .flow_en(flow_en2),
      .mixer_en(mixer_en2), .det_req(det_req2), .busy(busy2), .done(done2),
      .err(err2), .result(result2), .step(step2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] o, input logic [15:0] e);
      n_checks++;
      assert (o === e) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h at %0t", tag, o, e, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      if (busy) busy_cycles++;
   endtask

   task automatic phase(input logic [3:0] s, input int n, input logic [12:0] a);
      for (int i = 0; i < n; i++) begin
         chk("step", {12'h000, step}, {12'h000, s});
         chk("outs", {3'b000, obs}, {3'b000, a});
         tick();
      end
   endtask

   task automatic walk(input logic st_mixa, input logic dv_mixb);
      phase(4'd1, 4, A_FILL);
      phase(4'd2, 8, A_HEAT);
      start = st_mixa;
      phase(4'd3, 6, A_MIXA);
      start = 1'b0;
      phase(4'd4, 3, A_FILT);
      det_valid = dv_mixb;
      det_value = 8'h77;
      phase(4'd5, 6, A_MIXB);
      det_valid = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b1; abort = 1'b0; det_valid = 1'b0;
      det_value = 8'h00; start2 = 1'b0;
      tick(); tick();
      chk("rst_step", {12'h000, step}, 16'h0000);
      chk("rst_outs", {3'b000, obs}, {3'b000, A_IDLE});
      chk("rst_result", {8'h00, result}, 16'h0000);

      // first edge with rst_n high accepts the held start
      rst_n = 1'b1;
      busy_cycles = 0;
      tick();
      start = 1'b0;
      walk(1'b0, 1'b0);
      phase(4'd6, 2, A_DET);
      chk("det3_step", {12'h000, step}, 16'h0006);
      det_valid = 1'b1; det_value = 8'hA5;
      tick();
      det_valid = 1'b0;
      chk("done_step", {12'h000, step}, 16'h0007);
      chk("done_outs", {3'b000, obs}, {3'b000, A_DONE});
      chk("done_result", {8'h00, result}, 16'h00A5);
      chk("busy_cycles", busy_cycles[15:0], 16'd30);

      // start and abort together from DONE: start wins; then detector timeout
      start = 1'b1; abort = 1'b1;
      tick();
      start = 1'b0; abort = 1'b0;
      chk("restart_outs", {3'b000, obs}, {3'b000, A_FILL});
      chk("restart_result", {8'h00, result}, 16'h00A5);
      walk(1'b1, 1'b1);
      phase(4'd6, 16, A_DET);
      chk("err_step", {12'h000, step}, 16'h0008);
      chk("err_outs", {3'b000, obs}, {3'b000, A_ERR});
      chk("err_result", {8'h00, result}, 16'h00A5);

      // abort on the 5th HEAT cycle, then a full restart
      start = 1'b1;
      tick();
      start = 1'b0;
      phase(4'd1, 4, A_FILL);
      phase(4'd2, 4, A_HEAT);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("abort_step", {12'h000, step}, 16'h0000);
      chk("abort_outs", {3'b000, obs}, {3'b000, A_IDLE});
      chk("abort_result", {8'h00, result}, 16'h00A5);
      start = 1'b1;
      tick();
      start = 1'b0;
      walk(1'b0, 1'b0);

      // det_valid together with abort on the first DETECT cycle
      chk("det1_step", {12'h000, step}, 16'h0006);
      det_valid = 1'b1; det_value = 8'h11; abort = 1'b1;
      tick();
      det_valid = 1'b0; abort = 1'b0;
      chk("dvab_step", {12'h000, step}, 16'h0000);
      chk("dvab_result", {8'h00, result}, 16'h00A5);

      // det_valid in the final timeout cycle
      start = 1'b1;
      tick();
      start = 1'b0;
      walk(1'b0, 1'b0);
      phase(4'd6, 15, A_DET);
      det_valid = 1'b1; det_value = 8'h3C;
      tick();
      det_valid = 1'b0;
      chk("tie_step", {12'h000, step}, 16'h0007);
      chk("tie_result", {8'h00, result}, 16'h003C);

      // reset during MIX_B clears result
      start = 1'b1;
      tick();
      start = 1'b0;
      phase(4'd1, 4, A_FILL);
      phase(4'd2, 8, A_HEAT);
      phase(4'd3, 6, A_MIXA);
      phase(4'd4, 3, A_FILT);
      phase(4'd5, 2, A_MIXB);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("mrst_step", {12'h000, step}, 16'h0000);
      chk("mrst_outs", {3'b000, obs}, {3'b000, A_IDLE});
      chk("mrst_result", {8'h00, result}, 16'h0000);

      // zero-length FILT lasts exactly one cycle
      start2 = 1'b1;
      tick();
      start2 = 1'b0;
      chk("f0_fill", {12'h000, step2}, 16'h0001);
      repeat (18) tick();
      chk("f0_filt", {12'h000, step2}, 16'h0004);
      tick();
      chk("f0_mixb", {12'h000, step2}, 16'h0005);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
